leaf_controller: RTL and testbench
==================================

Name: leaf_controller

Overview:
- Leaf-FPGA end of the root hub control protocol.
- Accepts 64-bit control words arriving from the root over the downlink and tracks the decode handshake: start message, then measurement header, then measurement data words.
- Streams the measurement words into the local decoder array, launches the decode and times it.
- Returns one result word to the root over the uplink.
- Sits between the leaf's downlink/uplink FIFOs and the local decoding array.

Parameters:
- FPGA_ID, 8'd1, this leaf's address; matched against the destination byte of incoming control words.
- ROOT_ID, 8'd0, destination byte placed in result words.
- START_DECODING_MSG, 8'h01, message-type code of the start message.
- MEASUREMENT_DATA_HEADER, 8'h02, message-type code of the measurement header.
- RESULT_MSG, 8'h03, message-type code of the result word.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-low reset; logic is held in reset while reset == 0.
- rx_data  input  64  downlink word from the root.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  controller accepts rx_data.
- tx_data  output  64  result word to the root.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  uplink accepts tx_data.
- meas_data  output  64  measurement word to the decoder.
- meas_valid  output  1  meas_data valid.
- meas_ready  input  1  decoder accepts meas_data.
- decode_start  output  1  single-cycle pulse that launches decoding.
- decode_done  input  1  decoder finished; level or pulse.
- decode_iterations  input  8  iteration count from the decoder; sampled when decode_done is seen.

Behaviour:
- Handshake rules: a transfer occurs when valid && ready are both high on a rising clk edge.
- Field layout of downlink control words:
  - [63:56] destination.
  - [47:40] message type.
  - Start message: [0] = multi_fpga_run flag.
  - Header: [15:0] = N, the number of measurement words that follow.
- Address filter: a control word is "for us" when [63:56] == FPGA_ID or [63:56] == 8'hFF. Other control words are consumed (rx_ready = 1) and dropped. Data words are never filtered.
- States:
  - IDLE
    - rx_ready = 1.
    - A start message for us latches multi_fpga_run and moves to WAIT_HEADER.
    - Anything else is dropped.
  - WAIT_HEADER
    - rx_ready = 1.
    - A header for us loads remaining = N. Next state is LOAD_DATA if N != 0, otherwise START.
    - A start message for us re-latches the flag and stays in WAIT_HEADER.
    - Anything else is dropped.
  - LOAD_DATA
    - Pass-through: meas_data = rx_data, meas_valid = rx_valid, rx_ready = meas_ready.
    - Each transfer decrements remaining. The transfer that takes remaining from 1 to 0 moves to START.
  - START
    - decode_start = 1 for exactly one cycle; cycle counter cleared to 0.
    - Next state is RUNNING.
  - RUNNING
    - rx_ready = 0.
    - Counter increments every cycle in RUNNING, including the cycle in which decode_done is sampled high, so a done on the first RUNNING cycle reports 1.
    - Counter is 16 bits and saturates at 16'hFFFF; it does not wrap.
    - When decode_done == 1, register the result word and go to SEND_RESULT.
  - SEND_RESULT
    - tx_valid = 1, tx_data held stable, rx_ready = 0.
    - On tx handshake, next state is IDLE.
    - Backpressure (tx_ready = 0) holds indefinitely.
- Result word layout:
  - [63:56] ROOT_ID.
  - [55:48] RESULT_MSG.
  - [47:40] decode_iterations.
  - [39:24] cycle count.
  - [23:9] 0.
  - [8] multi_fpga_run.
  - [7:0] FPGA_ID.
- Outputs outside their owning state: meas_valid = 0, decode_start = 0, tx_valid = 0.
- decode_done sampled outside RUNNING is ignored.
- Reset:
  - Values: state = IDLE; counters = 0; flag = 0; tx_data = 0; tx_valid = 0; meas_valid = 0; decode_start = 0.
  - rx_ready is 0 while reset is asserted.
  - Reset asserted mid-operation aborts all activity, discards any pending result, and returns to IDLE after deassertion.
- Latency: the header with N = 0 accepted at cycle t gives decode_start at t+1 and RUNNING from t+2.

Test Plan:
- Start (dest FF, flag 0), then header N = 0, decoder done after 10 RUNNING cycles with iterations = 3 → one decode_start pulse; tx_data = {00, 03, 03, 16'd10, 15'b0, 1'b0, 01}.
- Header N = 4 followed by 4 data words, with meas_ready toggling 1,0,1,0 → exactly 4 meas transfers in order; rx_ready mirrors meas_ready; decode_start fires only after the 4th transfer.
- Start with dest 8'h05 (not FPGA_ID, not FF), then a header → both dropped; state stays IDLE; no decode_start.
- Decoder never raises done for 70000 cycles, then done → cycle field = 16'hFFFF; tx_ready held 0 for 20 cycles → tx_valid stays 1 and tx_data stays constant until accepted.
- Start with flag = 1, second start with flag = 0 while in WAIT_HEADER, then header N = 0 → result bit [8] = 0.
- reset pulsed low during LOAD_DATA with 2 of 4 words sent → all outputs return to reset values; a subsequent start/header sequence with N = 0 completes normally.

Source files
------------

// File: rtl/leaf_controller.sv
// Leaf end of the root hub control protocol: filters root control words, streams measurements to the decoder, times the decode, returns a result word.
// Latency: header with N = 0 accepted at t gives decode_start at t+1, RUNNING from t+2; result valid the cycle after decode_done is sampled.
// Backpressure: measurement words pass meas_ready straight back to rx_ready; the result word is held until tx_ready, with the downlink stalled meanwhile.
module leaf_controller #(
    parameter logic [7:0] FPGA_ID                 = 8'd1,
    parameter logic [7:0] ROOT_ID                 = 8'd0,
    parameter logic [7:0] START_DECODING_MSG      = 8'h01,
    parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02,
    parameter logic [7:0] RESULT_MSG              = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [63:0] meas_data,
    output logic        meas_valid,
    input  logic        meas_ready,
    output logic        decode_start,
    input  logic        decode_done,
    input  logic [7:0]  decode_iterations
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HEADER,
        S_LOAD_DATA,
        S_START,
        S_RUNNING,
        S_SEND_RESULT
    } state_t;

    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  msg_type;
        logic [7:0]  iterations;
        logic [15:0] cycles;
        logic [14:0] rsvd;
        logic        multi_fpga_run;
        logic [7:0]  src;
    } result_t;

    state_t      state;
    logic [15:0] remaining;
    logic [15:0] cycle_cnt;
    logic [15:0] cycle_next;
    logic        multi_fpga_run;
    result_t     result_q;
    logic        tx_valid_q;
    logic        decode_start_q;

    logic        for_us;
    logic        is_start;
    logic        is_header;
    logic        rx_fire;

    // Decode of the incoming control word and the saturating cycle count.
    always_comb begin
        for_us     = (rx_data[63:56] == FPGA_ID) || (rx_data[63:56] == 8'hFF);
        is_start   = (rx_data[47:40] == START_DECODING_MSG);
        is_header  = (rx_data[47:40] == MEASUREMENT_DATA_HEADER);
        rx_fire    = rx_valid && rx_ready;
        cycle_next = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
    end

    // Downlink ready: control states always accept, data state mirrors the decoder, stalled otherwise and in reset.
    always_comb begin
        rx_ready = 1'b0;
        if (reset) begin
            case (state)
                S_IDLE, S_WAIT_HEADER: rx_ready = 1'b1;
                S_LOAD_DATA:           rx_ready = meas_ready;
                default:               rx_ready = 1'b0;
            endcase
        end
    end

    assign meas_data    = rx_data;
    assign meas_valid   = (state == S_LOAD_DATA) && rx_valid;
    assign tx_data      = result_q;
    assign tx_valid     = tx_valid_q;
    assign decode_start = decode_start_q;

    // Protocol state machine with registered result, tx_valid and decode_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            remaining      <= 16'd0;
            cycle_cnt      <= 16'd0;
            multi_fpga_run <= 1'b0;
            result_q       <= '0;
            tx_valid_q     <= 1'b0;
            decode_start_q <= 1'b0;
        end else begin
            decode_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fire && for_us && is_start) begin
                        multi_fpga_run <= rx_data[0];
                        state          <= S_WAIT_HEADER;
                    end
                end
                S_WAIT_HEADER: begin
                    if (rx_fire && for_us) begin
                        if (is_header) begin
                            remaining <= rx_data[15:0];
                            if (rx_data[15:0] != 16'd0) begin
                                state <= S_LOAD_DATA;
                            end else begin
                                state          <= S_START;
                                decode_start_q <= 1'b1;
                            end
                        end else if (is_start) begin
                            // A repeated start simply refreshes the run flag.
                            multi_fpga_run <= rx_data[0];
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (rx_fire) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state          <= S_START;
                            decode_start_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    cycle_cnt <= 16'd0;
                    state     <= S_RUNNING;
                end
                S_RUNNING: begin
                    // The sampling cycle itself is counted, so done on the first cycle reports 1.
                    cycle_cnt <= cycle_next;
                    if (decode_done) begin
                        result_q <= '{dest:           ROOT_ID,
                                      msg_type:       RESULT_MSG,
                                      iterations:     decode_iterations,
                                      cycles:         cycle_next,
                                      rsvd:           15'd0,
                                      multi_fpga_run: multi_fpga_run,
                                      src:            FPGA_ID};
                        tx_valid_q <= 1'b1;
                        state      <= S_SEND_RESULT;
                    end
                end
                S_SEND_RESULT: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_controller.sv
// Directed plus randomized bench for leaf_controller with a transaction-level reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected result words come from the documented field layout and a saturating cycle count.
module tb_leaf_controller;

    logic        clk;
    logic        reset;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] meas_data;
    logic        meas_valid;
    logic        meas_ready;
    logic        decode_start;
    logic        decode_done;
    logic [7:0]  decode_iterations;

    int n_cmp;
    int n_fail;
    int n_starts;
    int exp_starts;

    logic [63:0] got_meas[$];
    logic [63:0] exp_meas[$];

    leaf_controller dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .meas_data         (meas_data),
        .meas_valid        (meas_valid),
        .meas_ready        (meas_ready),
        .decode_start      (decode_start),
        .decode_done       (decode_done),
        .decode_iterations (decode_iterations)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe measurement transfers and decode_start pulses.
    always @(negedge clk) begin
        if (reset && meas_valid && meas_ready) got_meas.push_back(meas_data);
        if (reset && decode_start) n_starts++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_start(input logic [7:0] dest, input logic flag);
        return {dest, 8'h00, 8'h01, 39'd0, flag};
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [7:0] dest, input logic [15:0] n);
        return {dest, 8'h00, 8'h02, 24'd0, n};
    endfunction

    // Reference result word: root dest, result type, iterations, saturated cycles, flag, our id.
    function automatic logic [63:0] exp_result(input logic [7:0] it, input int cycles, input logic flag);
        int c;
        c = (cycles > 65535) ? 65535 : cycles;
        return {8'h00, 8'h03, it, c[15:0], 15'd0, flag, 8'h01};
    endfunction

    task automatic send_ctrl(input logic [63:0] w);
        bit ok;
        ok = 1'b0;
        rx_data  = w;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("ctrl_accept", 64'(ok), 64'd1);
    endtask

    task automatic load_words(input int n, input bit toggle_first);
        int          sent;
        int          c;
        logic [63:0] w;
        sent = 0;
        c    = 0;
        w    = {$urandom, $urandom};
        while (sent < n && c < 500) begin
            meas_ready = (toggle_first && c < 4) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
            rx_data    = w;
            rx_valid   = 1'b1;
            @(negedge clk);
            check("rx_mirror", 64'(rx_ready), 64'(meas_ready));
            check("no_early_start", 64'(decode_start), 64'd0);
            if (meas_ready) begin
                exp_meas.push_back(w);
                sent++;
                w = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            c++;
        end
        rx_valid   = 1'b0;
        meas_ready = 1'b1;
        check("load_count", 64'(sent), 64'(n));
    endtask

    task automatic check_meas();
        check("meas_count", 64'(got_meas.size()), 64'(exp_meas.size()));
        for (int i = 0; i < exp_meas.size() && i < got_meas.size(); i++)
            check("meas_word", got_meas[i], exp_meas[i]);
        got_meas.delete();
        exp_meas.delete();
    endtask

    // Wait for the launch, raise done on RUNNING cycle k, then check and drain the result word.
    task automatic do_decode(input int k, input logic [7:0] it, input logic flag, input int hold);
        bit          seen;
        logic [63:0] first;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (decode_start) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
        exp_starts++;
        decode_iterations = it;
        repeat (k) @(posedge clk);
        #1;
        decode_done = 1'b1;
        @(posedge clk);
        #1;
        decode_done       = 1'b0;
        decode_iterations = ~it;
        @(negedge clk);
        check("tx_valid_up", 64'(tx_valid), 64'd1);
        check("tx_data", tx_data, exp_result(it, k, flag));
        first = tx_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("tx_hold_valid", 64'(tx_valid), 64'd1);
            check("tx_hold_data", tx_data, first);
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check("tx_valid_down", 64'(tx_valid), 64'd0);
        check("start_count", 64'(n_starts), 64'(exp_starts));
        check_meas();
    endtask

    logic [7:0] rdest;
    logic       rflag;
    int         rn;

    initial begin
        n_cmp = 0; n_fail = 0; n_starts = 0; exp_starts = 0;
        reset = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        meas_ready = 1'b1; decode_done = 1'b0; decode_iterations = 8'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_meas_valid", 64'(meas_valid), 64'd0);
        check("rst_decode_start", 64'(decode_start), 64'd0);
        check("rst_tx_data", tx_data, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Broadcast start, empty header, done after 10 cycles.
        send_ctrl(mk_start(8'hFF, 1'b0));
        send_ctrl(mk_hdr(8'h01, 16'd0));
        do_decode(10, 8'd3, 1'b0, 0);

        // Four data words with meas_ready toggling.
        send_ctrl(mk_start(8'h01, 1'b1));
        send_ctrl(mk_hdr(8'hFF, 16'd4));
        load_words(4, 1'b1);
        do_decode(int'($urandom_range(1, 15)), 8'($urandom), 1'b1, 2);

        // Words for another leaf are dropped; done outside RUNNING is ignored.
        decode_done = 1'b1;
        send_ctrl(mk_start(8'h05, 1'b1));
        send_ctrl(mk_hdr(8'h01, 16'd0));
        for (int i = 0; i < 3; i++) begin
            rdest = 8'($urandom_range(2, 254));
            send_ctrl(mk_start(rdest, 1'b0));
            send_ctrl(mk_hdr(8'h01, 16'd0));
        end
        repeat (5) begin
            @(negedge clk);
            check("drop_no_start", 64'(decode_start), 64'd0);
            check("drop_no_tx", 64'(tx_valid), 64'd0);
        end
        decode_done = 1'b0;
        check("drop_start_count", 64'(n_starts), 64'(exp_starts));

        // Saturating counter and long uplink backpressure.
        send_ctrl(mk_start(8'h01, 1'b0));
        send_ctrl(mk_hdr(8'h01, 16'd0));
        do_decode(70000, 8'hA5, 1'b0, 20);

        // Second start in WAIT_HEADER overrides the flag.
        send_ctrl(mk_start(8'h01, 1'b1));
        send_ctrl(mk_start(8'hFF, 1'b0));
        send_ctrl(mk_hdr(8'h01, 16'd0));
        do_decode(5, 8'd7, 1'b0, 0);

        // Reset in the middle of a data load.
        send_ctrl(mk_start(8'h01, 1'b1));
        send_ctrl(mk_hdr(8'h01, 16'd4));
        load_words(2, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rx_ready", 64'(rx_ready), 64'd0);
        check("mid_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_meas_valid", 64'(meas_valid), 64'd0);
        check("mid_decode_start", 64'(decode_start), 64'd0);
        check("mid_tx_data", tx_data, 64'd0);
        check_meas();
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_ctrl(mk_start(8'hFF, 1'b1));
        send_ctrl(mk_hdr(8'h01, 16'd0));
        do_decode(4, 8'd9, 1'b1, 1);

        // Randomized transactions with interleaved foreign traffic.
        for (int t = 0; t < 8; t++) begin
            send_ctrl(mk_start(8'($urandom_range(2, 254)), 1'($urandom)));
            rflag = 1'($urandom);
            send_ctrl(mk_start(($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF, rflag));
            send_ctrl(mk_hdr(8'($urandom_range(2, 254)), 16'd0));
            rn = int'($urandom_range(0, 6));
            send_ctrl(mk_hdr(($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF, 16'(rn)));
            if (rn != 0) load_words(rn, 1'b0);
            do_decode(int'($urandom_range(1, 30)), 8'($urandom), rflag, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
